// File: rtl/io_port_bridge_pkg.sv
// rtl/io_port_bridge_pkg.sv - shared types and helpers for the CPU I/O port bridge
// Contents:
//   DATA_W_DEFAULT  default word width (CPU bus width)
//   rx_state_t      RX hold-register FSM states
//   clog2           ceiling log2, used to size FIFO pointers
package io_bridge_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_HELD  = 1'b1
  } rx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/io_port_bridge_if.sv
// rtl/io_port_bridge_if.sv - CPU and device side signals of the I/O port bridge
// Ports (bridge view, modport slave):
//   in : out_wr, out_data, in_rd, dev_tx_ready, dev_rx_data, dev_rx_valid
//   out: in_port_data, in_port_valid, out_full, drop_count,
//        dev_tx_data, dev_tx_valid, dev_rx_ready
// modport master is the environment view (CPU plus device) with directions reversed.
interface io_port_bridge_if #(
  parameter int DATA_W = io_bridge_pkg::DATA_W_DEFAULT,
  parameter int CNT_W  = 8
);
  logic              out_wr;
  logic [DATA_W-1:0] out_data;
  logic              in_rd;
  logic [DATA_W-1:0] in_port_data;
  logic              in_port_valid;
  logic              out_full;
  logic [CNT_W-1:0]  drop_count;
  logic [DATA_W-1:0] dev_tx_data;
  logic              dev_tx_valid;
  logic              dev_tx_ready;
  logic [DATA_W-1:0] dev_rx_data;
  logic              dev_rx_valid;
  logic              dev_rx_ready;

  modport slave (
    input  out_wr, out_data, in_rd, dev_tx_ready, dev_rx_data, dev_rx_valid,
    output in_port_data, in_port_valid, out_full, drop_count,
           dev_tx_data, dev_tx_valid, dev_rx_ready
  );

  modport master (
    output out_wr, out_data, in_rd, dev_tx_ready, dev_rx_data, dev_rx_valid,
    input  in_port_data, in_port_valid, out_full, drop_count,
           dev_tx_data, dev_tx_valid, dev_rx_ready
  );

endinterface

// File: rtl/io_port_bridge_sync_fifo.sv
// rtl/io_port_bridge_sync_fifo.sv - show-ahead synchronous FIFO for the OutPort path
// Ports:
//   clock, clear  rising-edge clock, asynchronous active-high reset
//   push, data    write data when push=1 (caller guarantees room or a same-cycle pop)
//   pop           discard head word (caller guarantees not empty)
//   head          current head word, 0 while empty
//   empty, full   occupancy flags derived from the registered pointers
module sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // The extra pointer MSB separates full from empty when the index bits match.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - device-side bridge for the CPU InPort/OutPort pair
// Ports:
//   clock, clear  rising-edge clock, asynchronous active-high reset
//   bus           io_port_bridge_if.slave:
//                   OutPort words (out_wr/out_data) are queued and drained to
//                   the device on dev_tx_*; device words on dev_rx_* are held
//                   one at a time for the CPU on in_port_*, consumed by in_rd.
//                   out_full and a saturating drop_count report lost writes.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input logic               clock,
  input logic               clear,
  io_port_bridge_if.slave   bus
);

  // TX path
  logic              tx_empty;
  logic              tx_full;
  logic              tx_push;
  logic              tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic [CNT_W-1:0]  drop_q;

  assign tx_pop  = !tx_empty && bus.dev_tx_ready;
  // A write into a full FIFO still lands if the head leaves in the same cycle.
  assign tx_push = bus.out_wr && (!tx_full || tx_pop);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_tx_fifo (
    .clock (clock),
    .clear (clear),
    .push  (tx_push),
    .pop   (tx_pop),
    .data  (bus.out_data),
    .head  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      drop_q <= '0;
    end else if (bus.out_wr && !tx_push && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign bus.dev_tx_valid = !tx_empty;
  assign bus.dev_tx_data  = tx_head;
  assign bus.out_full     = tx_full;
  assign bus.drop_count   = drop_q;

  // RX path
  rx_state_t         rx_state;
  rx_state_t         rx_state_next;
  logic              rx_ready;
  logic              rx_load;
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) rx_state <= RX_EMPTY;
    else       rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_ready      = 1'b0;
    case (rx_state)
      RX_EMPTY: begin
        rx_ready = 1'b1;
        if (bus.dev_rx_valid) rx_state_next = RX_HELD;
      end
      RX_HELD: begin
        // The slot frees exactly when the CPU consumes it, so a waiting
        // device word can refill it in that same cycle.
        rx_ready = bus.in_rd;
        if (bus.in_rd && !bus.dev_rx_valid) rx_state_next = RX_EMPTY;
      end
      default: rx_state_next = RX_EMPTY;
    endcase
  end

  assign rx_load = rx_ready && bus.dev_rx_valid;

  // hold_q is deliberately not cleared on consume; the CPU may read it stale.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)        hold_q <= '0;
    else if (rx_load) hold_q <= bus.dev_rx_data;
  end

  assign bus.in_port_data  = hold_q;
  assign bus.in_port_valid = (rx_state == RX_HELD);
  assign bus.dev_rx_ready  = rx_ready && !clear;

endmodule

// File: tb/tb_io_port_bridge.sv
// tb/tb_io_port_bridge.sv - self-checking bench for io_port_bridge
module tb_io_port_bridge;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic clear = 1'b0;
  bit   started = 1'b0;

  int checks = 0;
  int errors = 0;

  io_port_bridge_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  io_port_bridge #(
    .DATA_W    (DW),
    .OUT_DEPTH (DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: a word queue for TX, a held flag plus word for RX.
  logic [DW-1:0] m_q[$];
  int            m_drop;
  bit            m_held;
  logic [DW-1:0] m_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop = 0;
    m_held = 1'b0;
    m_word = '0;
  endtask

  task automatic model_step();
    bit pop, was_full, accept;
    pop      = (m_q.size() != 0) && bus.dev_tx_ready;
    was_full = (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (bus.out_wr) begin
      if (!was_full || pop) m_q.push_back(bus.out_data);
      else if (m_drop < DROP_MAX) m_drop++;
    end
    accept = bus.dev_rx_valid && (!m_held || bus.in_rd);
    if (accept) begin
      m_word = bus.dev_rx_data;
      m_held = 1'b1;
    end else if (m_held && bus.in_rd) begin
      m_held = 1'b0;
    end
  endtask

  task automatic cycle(input bit wr, input logic [DW-1:0] wd, input bit rd,
                       input bit txr, input bit rxv, input logic [DW-1:0] rxd);
    bus.out_wr       = wr;
    bus.out_data     = wd;
    bus.in_rd        = rd;
    bus.dev_tx_ready = txr;
    bus.dev_rx_valid = rxv;
    bus.dev_rx_data  = rxd;
    @(posedge clock);
    model_step();
    #1;
  endtask

  // Called at posedge+1; asserts clear mid-cycle and releases it one edge later.
  task automatic do_clear(input bit literal);
    #2;
    clear = 1'b1;
    #1;
    model_reset();
    if (literal) begin
      chk("rst_tx_valid", bus.dev_tx_valid, 0);
      chk("rst_tx_data", bus.dev_tx_data, 0);
      chk("rst_out_full", bus.out_full, 0);
      chk("rst_drop", bus.drop_count, 0);
      chk("rst_in_valid", bus.in_port_valid, 0);
      chk("rst_in_data", bus.in_port_data, 0);
      chk("rst_rx_ready", bus.dev_rx_ready, 0);
    end
    @(posedge clock);
    #1;
    bus.out_wr = 0; bus.in_rd = 0; bus.dev_tx_ready = 0; bus.dev_rx_valid = 0;
    clear = 1'b0;
    #1;
    if (literal) begin
      chk("rel_rx_ready", bus.dev_rx_ready, 1);
      chk("rel_tx_valid", bus.dev_tx_valid, 0);
    end
  endtask

  // Compare process: every cycle outside reset, the DUT must match the model.
  always @(negedge clock) begin
    if (started && !clear) begin
      chk("cmp_tx_valid", bus.dev_tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("cmp_tx_data", bus.dev_tx_data, m_q[0]);
      else                 chk("cmp_tx_data", bus.dev_tx_data, 0);
      chk("cmp_out_full", bus.out_full, m_q.size() == DEPTH);
      chk("cmp_drop", bus.drop_count, m_drop);
      chk("cmp_in_valid", bus.in_port_valid, m_held);
      chk("cmp_in_data", bus.in_port_data, m_word);
      chk("cmp_rx_ready", bus.dev_rx_ready, !m_held || bus.in_rd);
    end
  end

  initial begin
    int exp4[4];
    bus.out_wr = 0; bus.out_data = '0; bus.in_rd = 0;
    bus.dev_tx_ready = 0; bus.dev_rx_valid = 0; bus.dev_rx_data = '0;
    model_reset();
    #1 clear = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    started = 1'b1;
    #1;
    chk("init_rx_ready", bus.dev_rx_ready, 1);
    chk("init_tx_valid", bus.dev_tx_valid, 0);

    // 1. clear in the middle of traffic
    cycle(1, 32'hA5A5_0001, 0, 0, 1, 32'h0000_00AB);
    cycle(1, 32'hA5A5_0002, 0, 0, 0, 0);
    chk("pre_clear_valid", bus.in_port_valid, 1);
    do_clear(1);

    // 2. single write with an always-ready device
    cycle(1, 32'hDEAD_BEEF, 0, 1, 0, 0);
    chk("wr1_valid", bus.dev_tx_valid, 1);
    chk("wr1_data", bus.dev_tx_data, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 1, 0, 0);
    chk("wr1_gone", bus.dev_tx_valid, 0);

    // 3. overflow with a stalled device
    for (int i = 1; i <= 6; i++) begin
      cycle(1, i, 0, 0, 0, 0);
      if (i == 4) chk("ovf_full", bus.out_full, 1);
    end
    chk("ovf_drop", bus.drop_count, 2);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain", bus.dev_tx_data, k + 1);
      cycle(0, 0, 0, 1, 0, 0);
    end
    chk("ovf_empty", bus.dev_tx_valid, 0);

    // 4. push and pop together while full
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0, 0);
    cycle(1, 7, 0, 1, 0, 0);
    chk("pp_full", bus.out_full, 1);
    chk("pp_drop", bus.drop_count, 2);
    exp4 = '{2, 3, 4, 7};
    for (int k = 0; k < 4; k++) begin
      chk("pp_drain", bus.dev_tx_data, exp4[k]);
      cycle(0, 0, 0, 1, 0, 0);
    end
    chk("pp_empty", bus.dev_tx_valid, 0);

    // 5. RX back-to-back refill
    cycle(0, 0, 0, 0, 1, 32'h11);
    chk("rx_first", bus.in_port_data, 32'h11);
    chk("rx_first_v", bus.in_port_valid, 1);
    cycle(0, 0, 0, 0, 1, 32'h22);
    chk("rx_wait", bus.in_port_data, 32'h11);
    cycle(0, 0, 1, 0, 1, 32'h22);
    chk("rx_refill", bus.in_port_data, 32'h22);
    chk("rx_refill_v", bus.in_port_valid, 1);
    cycle(0, 0, 1, 0, 0, 0);
    chk("rx_drain_v", bus.in_port_valid, 0);
    chk("rx_drain_d", bus.in_port_data, 32'h22);

    // 6. stale read in EMPTY
    cycle(0, 0, 1, 0, 0, 0);
    chk("stale_v", bus.in_port_valid, 0);
    chk("stale_d", bus.in_port_data, 32'h22);

    // drop counter saturation
    do_clear(0);
    for (int i = 0; i < DROP_MAX + 20; i++) cycle(1, i, 0, 0, 0, 0);
    chk("sat_drop", bus.drop_count, DROP_MAX);
    cycle(1, 32'h55, 0, 0, 0, 0);
    chk("sat_hold", bus.drop_count, DROP_MAX);

    // randomized traffic, with occasional clears
    do_clear(0);
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = (n / 250) % 4;
      cycle($urandom_range(0, 1), $urandom, ($urandom % 3) == 0,
            ($urandom % 4) < bias, $urandom_range(0, 1), $urandom);
      if ((n % 700) == 699) do_clear(0);
    end

    cycle(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
